// File: rtl/mem_access_unit.sv
// Load/store unit: turns M-stage accesses into lane-aligned, handshaked data-bus requests.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with an errM pulse.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        errM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // The counter only has to reach MAX_WAIT-1; the MAX_WAIT-th cycle is the timeout cycle.
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} stateE;

    stateE             stateQ, stateD;
    logic [CntW-1:0]   waitCntQ, waitCntD;
    logic              busReqQ, busReqD;
    logic              busWeQ, busWeD;
    logic [31:0]       busAddrQ, busAddrD;
    logic [3:0]        busBeQ, busBeD;
    logic [31:0]       busWdataQ, busWdataD;
    logic [31:0]       readQ, readD;
    logic              errQ, errD;
    logic [1:0]        sizeQ, sizeD;
    logic              signQ, signD;
    logic [1:0]        offQ, offD;
    logic              misaligned;

    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   laneMask = 4'b0001 << off;
            2'b01:   laneMask = off[1] ? 4'b1100 : 4'b0011;
            default: laneMask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   storeData = {4{data[7:0]}};
            2'b01:   storeData = {2{data[15:0]}};
            default: storeData = data;
        endcase
    endfunction

    function automatic logic [31:0] formatLoad(input logic [1:0] size, input logic sign,
                                               input logic [1:0] off, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   formatLoad = {{24{sign & b[7]}}, b};
            2'b01:   formatLoad = {{16{sign & h[15]}}, h};
            default: formatLoad = rdata;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((memsizeM == 2'b01) && aluoutM[0]) ||
                        (memsizeM[1] && (aluoutM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        stateD    = stateQ;
        waitCntD  = waitCntQ;
        busReqD   = busReqQ;
        busWeD    = busWeQ;
        busAddrD  = busAddrQ;
        busBeD    = busBeQ;
        busWdataD = busWdataQ;
        readD     = readQ;
        errD      = 1'b0;
        sizeD     = sizeQ;
        signD     = signQ;
        offD      = offQ;
        stallM    = 1'b0;

        case (stateQ)
            StIdle: begin
                if (memreqM) begin
                    busWeD    = memwriteM;
                    busAddrD  = {aluoutM[31:2], 2'b00};
                    busBeD    = laneMask(memsizeM, aluoutM[1:0]);
                    busWdataD = storeData(memsizeM, writedataM);
                    sizeD     = memsizeM;
                    signD     = memsignM;
                    offD      = aluoutM[1:0];
                    waitCntD  = '0;
                    if (misaligned) begin
                        stateD = StDone;
                        errD   = 1'b1;
                        if (!memwriteM) readD = '0;
                    end else begin
                        stateD  = StAccess;
                        busReqD = 1'b1;
                        stallM  = 1'b1;
                    end
                end
            end
            StAccess: begin
                stallM = 1'b1;
                // An ack in the timeout cycle still completes normally.
                if (bus_ack) begin
                    busReqD = 1'b0;
                    if (!busWeQ) readD = formatLoad(sizeQ, signQ, offQ, bus_rdata);
                    stateD  = StDone;
                end else if (waitCntQ == CntW'(MAX_WAIT - 1)) begin
                    busReqD = 1'b0;
                    readD   = '0;
                    errD    = 1'b1;
                    stateD  = StDone;
                end else begin
                    waitCntD = waitCntQ + CntW'(1);
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StIdle;
            waitCntQ  <= '0;
            busReqQ   <= 1'b0;
            busWeQ    <= 1'b0;
            busAddrQ  <= '0;
            busBeQ    <= 4'b0000;
            busWdataQ <= '0;
            readQ     <= '0;
            errQ      <= 1'b0;
            sizeQ     <= 2'b00;
            signQ     <= 1'b0;
            offQ      <= 2'b00;
        end else begin
            stateQ    <= stateD;
            waitCntQ  <= waitCntD;
            busReqQ   <= busReqD;
            busWeQ    <= busWeD;
            busAddrQ  <= busAddrD;
            busBeQ    <= busBeD;
            busWdataQ <= busWdataD;
            readQ     <= readD;
            errQ      <= errD;
            sizeQ     <= sizeD;
            signQ     <= signD;
            offQ      <= offD;
        end
    end

    assign readdataM = readQ;
    assign errM      = errQ;
    assign bus_req   = busReqQ;
    assign bus_we    = busWeQ;
    assign bus_addr  = busAddrQ;
    assign bus_be    = busBeQ;
    assign bus_wdata = busWdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model, per-cycle compare and directed pins.
module tb_mem_access_unit;

    localparam int unsigned MaxWait = 4;

    logic        clk, rst, memreqM, memwriteM, memsignM, bus_ack;
    logic [1:0]  memsizeM;
    logic [31:0] aluoutM, writedataM, readdataM, bus_addr, bus_wdata, bus_rdata;
    logic        stallM, errM, bus_req, bus_we;
    logic [3:0]  bus_be;

    int total = 0;
    int bad = 0;

    logic        checkOn;
    logic        expStall, expReq, expErr, expWe;
    logic [31:0] expAddr, expWdata, expRead;
    logic [3:0]  expBe;

    int          stallCnt;
    logic        doneErr, sawReq, obsWe;
    logic [31:0] obsAddr, obsWdata;
    logic [3:0]  obsBe;

    mem_access_unit #(.MAX_WAIT(MaxWait)) dut (
        .clk(clk), .rst(rst), .memreqM(memreqM), .memwriteM(memwriteM), .memsizeM(memsizeM),
        .memsignM(memsignM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
        .stallM(stallM), .errM(errM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int laneBase(input logic [1:0] sz, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        return off - (off % nBytes(sz));
    endfunction

    function automatic logic [3:0] beModel(input logic [1:0] sz, input logic [31:0] addr);
        return 4'(((1 << nBytes(sz)) - 1) << laneBase(sz, addr));
    endfunction

    function automatic logic [31:0] wdataModel(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (sz == 2'b01) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] loadModel(input logic [1:0] sz, input logic sg,
                                              input logic [31:0] addr, input logic [31:0] rd);
        int nb;
        logic [31:0] v, mask;
        nb   = nBytes(sz);
        v    = rd >> (8 * laneBase(sz, addr));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic misModel(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checkOn) begin
            chk("stallM", {31'b0, stallM}, {31'b0, expStall});
            chk("bus_req", {31'b0, bus_req}, {31'b0, expReq});
            chk("errM", {31'b0, errM}, {31'b0, expErr});
            chk("readdataM", readdataM, expRead);
            if (expReq) begin
                chk("bus_we", {31'b0, bus_we}, {31'b0, expWe});
                chk("bus_addr", bus_addr, expAddr);
                chk("bus_be", {28'b0, bus_be}, {28'b0, expBe});
                chk("bus_wdata", bus_wdata, expWdata);
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE. ackAt is the ACCESS cycle
    // (1-based) in which bus_ack is raised; 0 means never.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int ackAt, input logic [31:0] rd);
        logic mis, timeout, fin;
        int n;
        mis = misModel(sz, addr);
        timeout = 1'b0;
        memreqM = 1'b1; memwriteM = wr; memsizeM = sz; memsignM = sg;
        aluoutM = addr; writedataM = data; bus_rdata = rd; bus_ack = 1'b0;
        expWe = wr; expAddr = {addr[31:2], 2'b00}; expBe = beModel(sz, addr);
        expWdata = wdataModel(sz, data);
        expStall = !mis; expReq = 1'b0; expErr = 1'b0;
        stallCnt = 0; sawReq = 1'b0; doneErr = 1'b0;
        @(negedge clk);
        if (stallM) stallCnt++;
        @(posedge clk); #1;
        if (!mis) begin
            n = 0;
            fin = 1'b0;
            while (!fin) begin
                n++;
                bus_ack = (n == ackAt);
                expStall = 1'b1; expReq = 1'b1;
                @(negedge clk);
                if (stallM) stallCnt++;
                if (bus_req) begin
                    sawReq = 1'b1; obsWe = bus_we; obsAddr = bus_addr;
                    obsBe = bus_be; obsWdata = bus_wdata;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                if (n == ackAt) fin = 1'b1;
                else if (n == int'(MaxWait)) begin fin = 1'b1; timeout = 1'b1; end
            end
        end
        // DONE: memreqM still high and a stray ack must both be ignored.
        expStall = 1'b0; expReq = 1'b0; expErr = mis | timeout;
        if (timeout) expRead = '0;
        else if (mis) begin
            if (!wr) expRead = '0;
        end else if (!wr) expRead = loadModel(sz, sg, addr, rd);
        bus_ack = 1'b1; bus_rdata = ~rd;
        @(negedge clk);
        if (stallM) stallCnt++;
        if (bus_req) sawReq = 1'b1;
        doneErr = errM;
        @(posedge clk); #1;
        memreqM = 1'b0; bus_ack = 1'b0; expErr = 1'b0;
    endtask

    task automatic idle();
        memreqM = 1'b0; bus_ack = 1'b0;
        expStall = 1'b0; expReq = 1'b0; expErr = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; checkOn = 1'b0;
        memreqM = 1'b0; memwriteM = 1'b0; memsizeM = 2'b00; memsignM = 1'b0;
        aluoutM = '0; writedataM = '0; bus_ack = 1'b0; bus_rdata = '0;
        expStall = 1'b0; expReq = 1'b0; expErr = 1'b0; expWe = 1'b0;
        expAddr = '0; expWdata = '0; expRead = '0; expBe = 4'b0000;
        obsWe = 1'b0; obsAddr = '0; obsWdata = '0; obsBe = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", {31'b0, bus_req}, 32'd0);
        chk("reset_be", {28'b0, bus_be}, 32'd0);
        chk("reset_addr", bus_addr, 32'd0);
        chk("reset_rdata", readdataM, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOn = 1'b1;
        idle();

        // Word store, zero-wait.
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1, 32'h0);
        chk("sw_addr", obsAddr, 32'h100);
        chk("sw_be", {28'b0, obsBe}, 32'hF);
        chk("sw_we", {31'b0, obsWe}, 32'd1);
        chk("sw_stall", stallCnt, 32'd2);

        // Byte loads from lane 3, signed then unsigned.
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h8012_3456);
        chk("lb_signed", readdataM, 32'hFFFF_FF80);
        chk("lb_be", {28'b0, obsBe}, 32'h8);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h8012_3456);
        chk("lbu", readdataM, 32'h0000_0080);

        // Half store, three wait cycles: ack lands on the timeout cycle and wins.
        access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234, 4, 32'h0);
        chk("sh_wdata", obsWdata, 32'h1234_1234);
        chk("sh_be", {28'b0, obsBe}, 32'hC);
        chk("sh_stall", stallCnt, 32'd5);
        chk("sh_noerr", {31'b0, doneErr}, 32'd0);

        // Signed half load from upper lanes with one wait cycle.
        access(1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 2, 32'h8001_7FFF);
        chk("lh_signed", readdataM, 32'hFFFF_8001);

        // Reset asserted mid-ACCESS.
        checkOn = 1'b0;
        memreqM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h40;
        writedataM = 32'h5555_5555; bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'b0, bus_req}, 32'd1);
        #2 rst = 1'b0; memreqM = 1'b0;
        #1;
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_we", {31'b0, bus_we}, 32'd0);
        chk("rst_err", {31'b0, errM}, 32'd0);
        chk("rst_be", {28'b0, bus_be}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", readdataM, 32'd0);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        expRead = '0;
        checkOn = 1'b1;
        idle();
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hCAFE_F00D);
        chk("post_rst_ld", readdataM, 32'hCAFE_F00D);

        // Load that never gets acked: timeout after MaxWait ACCESS cycles.
        access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'h1357_9BDF);
        chk("to_err", {31'b0, doneErr}, 32'd1);
        chk("to_rdata", readdataM, 32'd0);
        chk("to_stall", stallCnt, 32'd5);
        idle();

        // Byte store to lane 1, then size 11 treated as word.
        access(1'b1, 2'b00, 1'b0, 32'h001, 32'h0000_00A5, 1, 32'h0);
        chk("sb_wdata", obsWdata, 32'hA5A5_A5A5);
        chk("sb_be", {28'b0, obsBe}, 32'h2);
        access(1'b1, 2'b11, 1'b0, 32'h008, 32'h0BAD_CAFE, 1, 32'h0);
        chk("s11_be", {28'b0, obsBe}, 32'hF);

        // Word load at 0x101.
        access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h1122_3344);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_noreq", {31'b0, sawReq}, 32'd0);
        chk("mis_stall", stallCnt, 32'd0);
        chk("mis_err", {31'b0, doneErr}, 32'd1);
        chk("mis_rdata", readdataM, 32'd0);
`else
        chk("mis_addr", obsAddr, 32'h100);
        chk("mis_rdata", readdataM, 32'h1122_3344);
        chk("mis_err", {31'b0, doneErr}, 32'd0);
        chk("mis_stall", stallCnt, 32'd2);
`endif

        // Unsigned half load at odd address: model decides aligned or rejected.
        access(1'b0, 2'b01, 1'b0, 32'h003, 32'h0, 1, 32'hBEEF_0123);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
